// File: rtl/spi_master_mc.sv
// spi_master_mc: SPI master supporting CPOL/CPHA modes 0-3, a programmable SCK
// half-period divider (H = clk_div+1 clk cycles), NUM_CS one-hot active-low chip
// selects and full-duplex DATA_WIDTH-bit frames.
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input (LSB-first frames).
module spi_master_mc #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_CS     = 4,
   parameter int unsigned DIV_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      send,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic [1:0]                mode,
   input  logic [$clog2(NUM_CS):0]   cs_sel,
   input  logic [DIV_WIDTH-1:0]      clk_div,
`ifdef SPI_LSB_FIRST_EN
   input  logic                      lsb_first,
`endif
   input  logic                      miso,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      sck,
   output logic [NUM_CS-1:0]         cs_n,
   output logic                      mosi
);

   localparam int unsigned SEL_W     = $clog2(NUM_CS) + 1;
   localparam int unsigned EDGE_W    = $clog2(2 * DATA_WIDTH);
   localparam int unsigned LAST_EDGE = 2 * DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [EDGE_W-1:0]     edge_q, edge_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic                  lsb_q, lsb_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] data_out_d;
   logic                  busy_d, done_d, sck_d, mosi_d;
   logic [NUM_CS-1:0]     cs_n_d;
   logic                  lsb_in;
   logic                  tick;
   logic                  leading;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // Bit presented on mosi from the head of a tx shift value
   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_WIDTH-1];
   endfunction

   // Tx shift register advance, direction follows the frame bit order
   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                       input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   // Rx shift register insert; first received bit ends at bit 0 when lsb is set
   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                      input logic lsb, input logic b);
      return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
   endfunction

   // Half-period strobe and edge classification (leading = moving away from CPOL)
   assign tick    = (cnt_q == div_q);
   assign leading = (sck == cpol_q);

   // State and output registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         div_q    <= '0;
         edge_q   <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         tx_q     <= '0;
         rx_q     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         sck      <= 1'b0;
         cs_n     <= '1;
         mosi     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         edge_q   <= edge_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         lsb_q    <= lsb_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         busy     <= busy_d;
         done     <= done_d;
         data_out <= data_out_d;
         sck      <= sck_d;
         cs_n     <= cs_n_d;
         mosi     <= mosi_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      edge_d     = edge_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      busy_d     = busy;
      done_d     = 1'b0;
      data_out_d = data_out;
      sck_d      = sck;
      cs_n_d     = cs_n;
      mosi_d     = mosi;

      case (state_q)
         ST_IDLE: begin
            sck_d  = mode[1];
            cs_n_d = '1;
            busy_d = 1'b0;
            if (send && (cs_sel < SEL_W'(NUM_CS))) begin
               state_d = ST_SETUP;
               cnt_d   = '0;
               div_d   = clk_div;
               cpol_d  = mode[1];
               cpha_d  = mode[0];
               lsb_d   = lsb_in;
               rx_d    = '0;
               busy_d  = 1'b1;
               cs_n_d  = ~(NUM_CS'(1) << cs_sel);
               if (!mode[0]) begin
                  mosi_d = first_bit(data_in, lsb_in);
                  tx_d   = shift_out(data_in, lsb_in);
               end else begin
                  tx_d   = data_in;
               end
            end
         end

         ST_SETUP: begin
            cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
            if (tick) begin
               state_d = ST_XFER;
               edge_d  = EDGE_W'(LAST_EDGE);
            end
         end

         ST_XFER: begin
            cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
            if (tick) begin
               sck_d = ~sck;
               if (leading != cpha_q) begin
                  rx_d = shift_in(rx_q, lsb_q, miso);
               end else if (edge_q != '0) begin
                  mosi_d = first_bit(tx_q, lsb_q);
                  tx_d   = shift_out(tx_q, lsb_q);
               end
               if (edge_q == '0) begin
                  state_d = ST_HOLD;
               end else begin
                  edge_d = edge_q - EDGE_W'(1);
               end
            end
         end

         ST_HOLD: begin
            cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
            if (tick) begin
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               cs_n_d     = '1;
               data_out_d = rx_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc with a behavioural SPI slave (or mosi loopback).
module tb_spi_master_mc;

   localparam int unsigned DW   = 8;
   localparam int unsigned NCS  = 4;
   localparam int unsigned DIVW = 8;

   logic            clk = 1'b0;
   logic            arst_n = 1'b1;
   logic            send = 1'b0;
   logic [DW-1:0]   data_in = '0;
   logic [1:0]      mode = 2'd0;
   logic [2:0]      cs_sel = 3'd0;
   logic [DIVW-1:0] clk_div = '0;
`ifdef SPI_LSB_FIRST_EN
   logic            lsb_first = 1'b0;
`endif
   logic            miso;
   logic            busy, done, sck, mosi;
   logic [DW-1:0]   data_out;
   logic [NCS-1:0]  cs_n;

   spi_master_mc #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW)) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .send     (send),
      .data_in  (data_in),
      .mode     (mode),
      .cs_sel   (cs_sel),
      .clk_div  (clk_div),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .miso     (miso),
      .busy     (busy),
      .done     (done),
      .data_out (data_out),
      .sck      (sck),
      .cs_n     (cs_n),
      .mosi     (mosi)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural slave: shifts s_data out and collects mosi into s_rx
   logic [1:0] cur_mode = 2'd0;
   logic       cur_lsb = 1'b0;
   logic       loopback = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic [7:0] s_rx = 8'h00;
   int         s_idx = -1;
   logic       slave_miso;
   wire        cs_act = (cs_n != '1);

   always @(posedge cs_act) begin
      s_idx = cur_mode[0] ? -1 : 0;
      s_rx  = 8'h00;
   end

   always @(sck) begin : slave_edge
      logic lead;
      if (cs_act) begin
         lead = (sck != cur_mode[1]);
         if (lead != cur_mode[0]) s_rx = cur_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
         else                     s_idx++;
      end
   end

   assign slave_miso = (s_idx >= 0 && s_idx < 8) ? s_data[3'(cur_lsb ? s_idx : 7 - s_idx)] : 1'b0;
   assign miso       = loopback ? mosi : slave_miso;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] div;
      logic [2:0] sel;
      logic [7:0] data;
      logic [7:0] slave;
      logic       loopb;
      logic [7:0] exp_data;
      logic [3:0] exp_cs;
      int         exp_busy;
   } vec_t;

   vec_t vecs [6];

   // Full frame: program, send, watch busy/sck/cs_n, then check done cycle
   task automatic run_frame(input vec_t v, input string tag);
      int   n;
      int   rises;
      logic prev_sck;
      logic cs_ok;
      @(negedge clk);
      mode     = v.mode;   clk_div  = v.div;  cs_sel = v.sel; data_in = v.data;
      cur_mode = v.mode;   s_data   = v.slave; loopback = v.loopb;
      @(negedge clk);
      check({tag, " idle_sck"}, 32'(sck), 32'(v.mode[1]));
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      n = 0; rises = 0; prev_sck = sck; cs_ok = 1'b1;
      while (busy && n < 20000) begin
         n++;
         if (cs_n !== v.exp_cs) cs_ok = 1'b0;
         if (sck && !prev_sck) rises++;
         prev_sck = sck;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, 32'(n), 32'(v.exp_busy));
      check({tag, " sck_rises"}, 32'(rises), 32'd8);
      check({tag, " cs_during_frame"}, 32'(cs_ok), 32'd1);
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " data_out"}, 32'(data_out), 32'(v.exp_data));
      check({tag, " cs_released"}, 32'(cs_n), 32'hF);
      check({tag, " slave_rx"}, 32'(s_rx), 32'(v.data));
      @(negedge clk);
      check({tag, " done_1clk"}, 32'(done), 32'd0);
   endtask

   initial begin
      int   n;
      int   t;
      int   dones;
      logic prev;
      logic idle_ok;

      //        mode  div     sel   data   slave  loop  exp    cs    busy
      vecs[0] = '{2'd0, 8'd1,   3'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 4'hE, 36};
      vecs[1] = '{2'd3, 8'd3,   3'd1, 8'h5A, 8'h3C, 1'b0, 8'h3C, 4'hD, 72};
      vecs[2] = '{2'd1, 8'd0,   3'd2, 8'hC3, 8'h96, 1'b0, 8'h96, 4'hB, 18};
      vecs[3] = '{2'd2, 8'd2,   3'd3, 8'h0F, 8'h96, 1'b0, 8'h96, 4'h7, 54};
      vecs[4] = '{2'd0, 8'd0,   3'd2, 8'hFF, 8'h00, 1'b0, 8'h00, 4'hB, 18};
      vecs[5] = '{2'd1, 8'd255, 3'd0, 8'h81, 8'h7E, 1'b0, 8'h7E, 4'hE, 4608};

      // Reset state
      #1 arst_n = 1'b0;
      #11;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst data_out", 32'(data_out), 32'd0);
      check("rst sck", 32'(sck), 32'd0);
      check("rst cs_n", 32'(cs_n), 32'hF);
      check("rst mosi", 32'(mosi), 32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Out-of-range chip select is ignored
      @(negedge clk);
      mode = 2'd0; clk_div = 8'd1; cs_sel = 3'd4; data_in = 8'h55; cur_mode = 2'd0;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      idle_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (busy !== 1'b0 || cs_n !== 4'hF) idle_ok = 1'b0;
         @(negedge clk);
      end
      check("bad_sel ignored", 32'(idle_ok), 32'd1);

      // Send mid-frame ignored, send in done cycle starts a second frame
      mode = 2'd0; clk_div = 8'd1; cs_sel = 3'd1; data_in = 8'h3C; cur_mode = 2'd0; loopback = 1'b1;
      @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      n = 0;
      while (!done && n < 1000) begin
         if (n == 10) begin
            send = 1'b1; data_in = 8'h00; cs_sel = 3'd0;
         end else if (n == 11) begin
            send = 1'b0; data_in = 8'hC3; cs_sel = 3'd1;
         end
         n++;
         @(negedge clk);
      end
      check("midsend busy_cycles", 32'(n), 32'd36);
      check("midsend data_out", 32'(data_out), 32'h3C);
      check("done_cycle cs_gap", 32'(cs_n), 32'hF);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      check("b2b busy", 32'(busy), 32'd1);
      check("b2b cs_n", 32'(cs_n), 32'hD);
      n = 0; dones = 0;
      while (busy && n < 1000) begin
         if (done) dones++;
         n++;
         @(negedge clk);
      end
      check("b2b busy_cycles", 32'(n), 32'd36);
      check("b2b no_done_while_busy", 32'(dones), 32'd0);
      check("b2b data_out", 32'(data_out), 32'hC3);
      @(negedge clk);
      @(negedge clk);
      check("b2b no_third_frame", 32'(busy), 32'd0);

      // Asynchronous reset mid-frame
      mode = 2'd0; clk_div = 8'd1; cs_sel = 3'd2; data_in = 8'h96; cur_mode = 2'd0; loopback = 1'b1;
      @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      n = 0; t = 0; prev = sck;
      while (t < 5 && n < 200) begin
         @(negedge clk);
         n++;
         if (sck !== prev) t++;
         prev = sck;
      end
      check("abort edges_seen", 32'(t), 32'd5);
      check("abort pre cs_n", 32'(cs_n), 32'hB);
      arst_n = 1'b0;
      #1;
      check("abort cs_n", 32'(cs_n), 32'hF);
      check("abort sck", 32'(sck), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      check("abort no_done", 32'(dones), 32'd0);
      run_frame(vecs[0], "after_abort");

`ifdef SPI_LSB_FIRST_EN
      // LSB-first loopback
      mode = 2'd0; clk_div = 8'd1; cs_sel = 3'd0; data_in = 8'h01; cur_mode = 2'd0;
      loopback = 1'b1; lsb_first = 1'b1; cur_lsb = 1'b1;
      @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      check("lsb first_mosi", 32'(mosi), 32'd1);
      n = 0;
      while (!done && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("lsb data_out", 32'(data_out), 32'h01);
      check("lsb slave_rx", 32'(s_rx), 32'h01);
      lsb_first = 1'b0; cur_lsb = 1'b0;
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
